// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer, reused by rename and the
// register file.
//   REG_WIDTH      : data / PC width
//   ROB_WIDTH_DEF  : default tag width
//   REG_IDX_W      : architectural register index width
//   rob_entry_t    : per-entry payload (busy/ready bits live beside it)
package reorder_buffer_pkg;

  localparam int REG_WIDTH     = 32;
  localparam int ROB_WIDTH_DEF = 4;
  localparam int REG_IDX_W     = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [REG_WIDTH-1:0] value;
    logic                 is_branch;
    logic                 pred_taken;
    logic [REG_WIDTH-1:0] alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer.
// Allocates tags at tail, captures results from two ALU writeback ports,
// answers two operand-readiness queries and retires one entry per cycle
// from head. Retiring a mispredicted branch raises clear_signal for one
// cycle with redirect_pc and empties the buffer.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low = hold everything)
//   issue*            : allocation request and entry fields
//   rd_issue_tag, full: tail index / full flag (combinational)
//   done/value/tag_alu_{1,2}: writeback ports (ALU1 wins on equal tags)
//   query_tag/ready/value_{1,2}: operand read ports (combinational)
//   commit_*          : registered retirement pulse and fields
//   clear_signal, redirect_pc: registered misprediction flush
// Build option: ROB_QUERY_BYPASS_EN lets queries and head commit see a
// same-cycle writeback.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int ROB_SIZE  = 2**ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_taken,
  input  logic [REG_WIDTH-1:0] issue_alt_pc,
  output logic [ROB_WIDTH-1:0] rd_issue_tag,
  output logic                 full,
  input  logic                 done_alu_1,
  input  logic                 done_alu_2,
  input  logic [REG_WIDTH-1:0] value_alu_1,
  input  logic [REG_WIDTH-1:0] value_alu_2,
  input  logic [ROB_WIDTH-1:0] tag_alu_1,
  input  logic [ROB_WIDTH-1:0] tag_alu_2,
  input  logic [ROB_WIDTH-1:0] query_tag_1,
  input  logic [ROB_WIDTH-1:0] query_tag_2,
  output logic                 query_ready_1,
  output logic                 query_ready_2,
  output logic [REG_WIDTH-1:0] query_value_1,
  output logic [REG_WIDTH-1:0] query_value_2,
  output logic                 commit_valid,
  output logic [REG_IDX_W-1:0] commit_rd,
  output logic [REG_WIDTH-1:0] commit_value,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic                 clear_signal,
  output logic [REG_WIDTH-1:0] redirect_pc
);

  rob_entry_t           ent_q [ROB_SIZE];
  rob_entry_t           ent_d [ROB_SIZE];
  logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commit_valid_q, commit_valid_d;
  logic [REG_IDX_W-1:0] commit_rd_q, commit_rd_d;
  logic [REG_WIDTH-1:0] commit_value_q, commit_value_d;
  logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
  logic                 clear_q, clear_d;
  logic [REG_WIDTH-1:0] redirect_q, redirect_d;

  logic                 issue_acc, wb1_ok, wb2_ok;
  logic                 head_ready, commit_go, mispredict;
  logic [REG_WIDTH-1:0] head_value;

  assign full         = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
  assign rd_issue_tag = tail_q;

  assign issue_acc = issue & ~full & ~clear_q;
  assign wb1_ok    = done_alu_1 & busy_q[tag_alu_1] & ~clear_q;
  assign wb2_ok    = done_alu_2 & busy_q[tag_alu_2] & ~clear_q;

  // Head readiness, optionally forwarded from this cycle's writeback.
  always_comb begin
    head_ready = ready_q[head_q];
    head_value = ent_q[head_q].value;
`ifdef ROB_QUERY_BYPASS_EN
    if (wb1_ok && tag_alu_1 == head_q) begin
      head_ready = 1'b1;
      head_value = value_alu_1;
    end else if (wb2_ok && tag_alu_2 == head_q) begin
      head_ready = 1'b1;
      head_value = value_alu_2;
    end
`endif
  end

  assign commit_go  = ~clear_q & busy_q[head_q] & head_ready;
  assign mispredict = ent_q[head_q].is_branch &
                      (head_value[0] != ent_q[head_q].pred_taken);

  // Read port 1
  always_comb begin
    query_ready_1 = ready_q[query_tag_1];
    query_value_1 = ent_q[query_tag_1].value;
`ifdef ROB_QUERY_BYPASS_EN
    if (wb1_ok && tag_alu_1 == query_tag_1) begin
      query_ready_1 = 1'b1;
      query_value_1 = value_alu_1;
    end else if (wb2_ok && tag_alu_2 == query_tag_1) begin
      query_ready_1 = 1'b1;
      query_value_1 = value_alu_2;
    end
`endif
  end

  // Read port 2
  always_comb begin
    query_ready_2 = ready_q[query_tag_2];
    query_value_2 = ent_q[query_tag_2].value;
`ifdef ROB_QUERY_BYPASS_EN
    if (wb1_ok && tag_alu_1 == query_tag_2) begin
      query_ready_2 = 1'b1;
      query_value_2 = value_alu_1;
    end else if (wb2_ok && tag_alu_2 == query_tag_2) begin
      query_ready_2 = 1'b1;
      query_value_2 = value_alu_2;
    end
`endif
  end

  always_comb begin
    ent_d          = ent_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    clear_d        = 1'b0;
    redirect_d     = redirect_q;

    if (issue_acc) begin
      ent_d[tail_q].rd         = issue_rd;
      ent_d[tail_q].value      = '0;
      ent_d[tail_q].is_branch  = issue_is_branch;
      ent_d[tail_q].pred_taken = issue_pred_taken;
      ent_d[tail_q].alt_pc     = issue_alt_pc;
      busy_d[tail_q]           = 1'b1;
      ready_d[tail_q]          = 1'b0;
      tail_d                   = tail_q + ROB_WIDTH'(1);
    end

    // ALU2 first so ALU1 overrides it on an equal tag.
    if (wb2_ok) begin
      ready_d[tag_alu_2]     = 1'b1;
      ent_d[tag_alu_2].value = value_alu_2;
    end
    if (wb1_ok) begin
      ready_d[tag_alu_1]     = 1'b1;
      ent_d[tag_alu_1].value = value_alu_1;
    end

    if (commit_go) begin
      commit_valid_d = 1'b1;
      commit_rd_d    = ent_q[head_q].is_branch ? '0 : ent_q[head_q].rd;
      commit_value_d = head_value;
      commit_tag_d   = head_q;
      busy_d[head_q] = 1'b0;
      head_d         = head_q + ROB_WIDTH'(1);
    end

    if (issue_acc && !commit_go)
      count_d = count_q + (ROB_WIDTH+1)'(1);
    else if (!issue_acc && commit_go)
      count_d = count_q - (ROB_WIDTH+1)'(1);

    // Flush wins over the issue/writeback updates made above.
    if (commit_go && mispredict) begin
      clear_d    = 1'b1;
      redirect_d = ent_q[head_q].alt_pc;
      busy_d     = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      clear_q        <= 1'b0;
      redirect_q     <= '0;
    end else if (rdy_in) begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      clear_q        <= clear_d;
      redirect_q     <= redirect_d;
    end
  end

  // Entry payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in) ent_q <= ent_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign clear_signal = clear_q;
  assign redirect_pc  = redirect_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a commit scoreboard (expected
// {tag, rd, value} pushed in program order, popped on each commit pulse)
// plus per-scenario inline checks of combinational and flush outputs.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int RW = 4;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in;
  logic            issue, issue_is_branch, issue_pred_taken;
  logic [4:0]      issue_rd;
  logic [31:0]     issue_alt_pc;
  logic [RW-1:0]   rd_issue_tag;
  logic            full;
  logic            done_alu_1, done_alu_2;
  logic [31:0]     value_alu_1, value_alu_2;
  logic [RW-1:0]   tag_alu_1, tag_alu_2, query_tag_1, query_tag_2;
  logic            query_ready_1, query_ready_2;
  logic [31:0]     query_value_1, query_value_2;
  logic            commit_valid, clear_signal;
  logic [4:0]      commit_rd;
  logic [31:0]     commit_value, redirect_pc;
  logic [RW-1:0]   commit_tag;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [RW+5+32-1:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue(issue), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .rd_issue_tag(rd_issue_tag), .full(full),
    .done_alu_1(done_alu_1), .done_alu_2(done_alu_2),
    .value_alu_1(value_alu_1), .value_alu_2(value_alu_2),
    .tag_alu_1(tag_alu_1), .tag_alu_2(tag_alu_2),
    .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
    .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
    .query_value_1(query_value_1), .query_value_2(query_value_2),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .clear_signal(clear_signal), .redirect_pc(redirect_pc)
  );

  // Scoreboard: every commit pulse must match the oldest expectation.
  always @(posedge clk_in) begin
    #2;
    if (!rst_in && commit_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got tag=%0d rd=%0d value=%h, expected none",
                 commit_tag, commit_rd, commit_value);
      end else begin
        logic [RW+5+32-1:0] e;
        e = exp_q.pop_front();
        if ({commit_tag, commit_rd, commit_value} !== e) begin
          n_fail++;
          $display("FAIL commit_fields: got tag=%0d rd=%0d value=%h, expected tag=%0d rd=%0d value=%h",
                   commit_tag, commit_rd, commit_value, e[40:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_idle();
    issue = 0; issue_rd = 0; issue_is_branch = 0; issue_pred_taken = 0;
    issue_alt_pc = 0; done_alu_1 = 0; done_alu_2 = 0; value_alu_1 = 0;
    value_alu_2 = 0; tag_alu_1 = 0; tag_alu_2 = 0; query_tag_1 = 0;
    query_tag_2 = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rdy_in = 1;
    rst_in = 1;
    tick();
    tick();
    rst_in = 0;
    exp_q.delete();
  endtask

  task automatic push_exp(input int tag, input int rd, input logic [31:0] v);
    exp_q.push_back({RW'(tag), 5'(rd), v});
  endtask

  task automatic issue_one(input int rd, input bit br, input bit pt, input logic [31:0] alt);
    issue = 1; issue_rd = 5'(rd); issue_is_branch = br;
    issue_pred_taken = pt; issue_alt_pc = alt;
    tick();
    issue = 0; issue_is_branch = 0;
  endtask

  task automatic wb1(input int tag, input logic [31:0] v);
    done_alu_1 = 1; tag_alu_1 = RW'(tag); value_alu_1 = v;
    tick();
    done_alu_1 = 0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d commits outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (full !== 1'b0)          begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    if (rd_issue_tag !== '0)    begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", rd_issue_tag); end
    if (commit_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
    if (clear_signal !== 1'b0)  begin n_fail++; $display("FAIL reset_clear: got %b expected 0", clear_signal); end
    if (redirect_pc !== '0)     begin n_fail++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc); end
  endtask

  task automatic test_fill_and_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_issue_tag !== RW'(i)) begin
        n_fail++; $display("FAIL fill_tag: got %0d expected %0d", rd_issue_tag, i);
      end
      issue_one(i + 1, 0, 0, 0);
    end
    n_cmp++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    issue_one(30, 0, 0, 0);  // 17th issue: ignored
    n_cmp += 2;
    if (rd_issue_tag !== '0) begin n_fail++; $display("FAIL overfill_tag: got %0d expected 0", rd_issue_tag); end
    if (full !== 1'b1)       begin n_fail++; $display("FAIL overfill_full: got %b expected 1", full); end

    for (int i = 0; i < 16; i++) push_exp(i, i + 1, 32'h100 + i);
    push_exp(0, 20, 32'h500);

    // Commit head and issue in the same cycle while full: issue rejected.
    done_alu_1 = 1; tag_alu_1 = 0; value_alu_1 = 32'h100;
`ifdef ROB_QUERY_BYPASS_EN
    issue = 1; issue_rd = 5'd31;
    tick();
    done_alu_1 = 0;
`else
    tick();
    done_alu_1 = 0;
    issue = 1; issue_rd = 5'd31;
    tick();
`endif
    issue = 0;
    n_cmp += 2;
    if (full !== 1'b0)       begin n_fail++; $display("FAIL commit_issue_full: got %b expected 0", full); end
    if (rd_issue_tag !== '0) begin n_fail++; $display("FAIL commit_issue_tag: got %0d expected 0", rd_issue_tag); end

    issue_one(20, 0, 0, 0);  // accepted at wrapped tag 0
    n_cmp += 2;
    if (rd_issue_tag !== RW'(1)) begin n_fail++; $display("FAIL wrap_tag: got %0d expected 1", rd_issue_tag); end
    if (full !== 1'b1)           begin n_fail++; $display("FAIL wrap_full: got %b expected 1", full); end

    for (int i = 1; i < 16; i++) wb1(i, 32'h100 + i);
    wb1(0, 32'h500);
    wait_drain("fill");
  endtask

  task automatic test_in_order();
    do_reset();
    issue_one(3, 0, 0, 0);
    issue_one(4, 0, 0, 0);
    push_exp(0, 3, 32'h11);
    push_exp(1, 4, 32'h22);
    wb1(1, 32'h22);
    tick();
    wb1(0, 32'h11);
    wait_drain("in_order");
  endtask

  task automatic test_dual_wb();
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(i + 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) push_exp(i, i + 1, 32'h40 + i);
    push_exp(3, 4, 32'hAA);
    done_alu_1 = 1; tag_alu_1 = 3; value_alu_1 = 32'hAA;
    done_alu_2 = 1; tag_alu_2 = 3; value_alu_2 = 32'hBB;
    tick();
    done_alu_1 = 0; done_alu_2 = 0;
    query_tag_1 = 3; query_tag_2 = 2;
    #1;
    n_cmp += 3;
    if (query_ready_1 !== 1'b1)    begin n_fail++; $display("FAIL dual_q_ready: got %b expected 1", query_ready_1); end
    if (query_value_1 !== 32'hAA)  begin n_fail++; $display("FAIL dual_q_value: got %h expected 000000aa", query_value_1); end
    if (query_ready_2 !== 1'b0)    begin n_fail++; $display("FAIL dual_q2_ready: got %b expected 0", query_ready_2); end
    for (int i = 0; i < 3; i++) wb1(i, 32'h40 + i);
    wait_drain("dual_wb");
  endtask

  task automatic test_branch_flush();
    int i;
    do_reset();
    issue_one(5, 0, 0, 0);
    issue_one(6, 0, 0, 0);
    issue_one(7, 1, 1, 32'h1000);
    issue_one(8, 0, 0, 0);
    push_exp(0, 5, 32'h50);
    push_exp(1, 6, 32'h60);
    push_exp(2, 0, 32'h0);
    wb1(3, 32'h33);  // younger than the branch: must be flushed
    wb1(0, 32'h50);
    wb1(1, 32'h60);
    wb1(2, 32'h0);
    for (i = 0; i < 10 && !clear_signal; i++) tick();
    n_cmp += 2;
    if (clear_signal !== 1'b1) begin
      n_fail++; $display("FAIL flush_raise: got clear=%b expected 1", clear_signal);
    end
    if (redirect_pc !== 32'h1000) begin
      n_fail++; $display("FAIL flush_redirect: got %h expected 00001000", redirect_pc);
    end
    issue = 1; issue_rd = 9;  // flush cycle: must be ignored
    tick();
    issue = 0;
    n_cmp += 4;
    if (clear_signal !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle: got %b expected 0", clear_signal); end
    if (full !== 1'b0)         begin n_fail++; $display("FAIL flush_full: got %b expected 0", full); end
    if (rd_issue_tag !== '0)   begin n_fail++; $display("FAIL flush_tag: got %0d expected 0", rd_issue_tag); end
    if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_commit: got %b expected 0", commit_valid); end
    wait_drain("branch");
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 6; i++) issue_one(i + 10, 0, 0, 0);
    for (int i = 0; i < 5; i++) push_exp(i, i + 10, 32'h70 + i);
    push_exp(5, 15, 32'h7);
    done_alu_2 = 1; tag_alu_2 = 5; value_alu_2 = 32'h7;
    query_tag_1 = 5; query_tag_2 = 4;
    #1;
    n_cmp += 2;
`ifdef ROB_QUERY_BYPASS_EN
    if (query_ready_1 !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %b expected 1", query_ready_1); end
    if (query_value_1 !== 32'h7) begin n_fail++; $display("FAIL bypass_value: got %h expected 00000007", query_value_1); end
`else
    if (query_ready_1 !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready: got %b expected 0", query_ready_1); end
    if (query_ready_2 !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready2: got %b expected 0", query_ready_2); end
`endif
    @(posedge clk_in); #1;
    done_alu_2 = 0;
    #1;
    n_cmp += 2;
    if (query_ready_1 !== 1'b1)  begin n_fail++; $display("FAIL stored_ready: got %b expected 1", query_ready_1); end
    if (query_value_1 !== 32'h7) begin n_fail++; $display("FAIL stored_value: got %h expected 00000007", query_value_1); end
    for (int i = 0; i < 5; i++) wb1(i, 32'h70 + i);
    wait_drain("query");
  endtask

  initial begin
    set_idle();
    rst_in = 1;
    rdy_in = 1;
    test_reset();
    test_fill_and_wrap();
    test_in_order();
    test_dual_wb();
    test_branch_flush();
    test_query_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
